piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 28 ++
 rtl/piso_cell.sv | 35 +++
 rtl/piso_serializer.sv | 137 +++++++++++++
 tb/tb_piso_serializer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared constants and FSM state encoding for the parallel-in / serial-out serializer.
// Optional feature macro: PISO_PARITY_EN adds the PARITY state.
`timescale 1ns/1ps
package piso_pkg;

   localparam int DEFAULT_WIDTH = 4;

`ifdef PISO_PARITY_EN
   localparam int STATE_W = 2;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;
`else
   localparam int STATE_W = 1;
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;
`endif

   // Bit-counter width; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/piso_cell.sv
// One shift-register bit: load value has priority over the neighbour bit, otherwise hold.
`timescale 1ns/1ps
module piso_cell (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_shift,
   input  logic i_load_val,
   input  logic i_nbr,
   output logic o_q
);

   logic r_q;
   logic w_d;

   always_comb begin
      w_d = r_q;
      if (i_load) begin
         w_d = i_load_val;
      end else if (i_shift) begin
         w_d = i_nbr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= 1'b0;
      end else begin
         r_q <= w_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a valid/ready word input and a framed bit output.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each frame.
`timescale 1ns/1ps
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               sout,
   output logic               sout_valid,
   output logic               done,
   output logic [STATE_W-1:0] dbg_state
);

   // Handshake: a word transfers at a posedge where in_valid && in_ready; in_ready
   // never depends on in_valid, and in/in_valid are ignored while in_ready is low.

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0] w_nbr;
   logic             w_last;
   logic             w_ready;
   logic             w_accept;
   logic             w_shift;
   logic             w_data_bit;

   assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_IDX);
   assign w_accept   = in_valid && w_ready;
   assign w_shift    = (r_state == SHIFT);
   assign w_data_bit = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];

`ifdef PISO_PARITY_EN
   logic r_parity;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= ^in;
      end
   end

   // The parity cycle takes over the end-of-frame role from the last data bit.
   assign w_ready = (r_state == IDLE) || (r_state == PARITY);
   assign done    = (r_state == PARITY);
   assign sout    = (r_state == PARITY) ? r_parity : (w_shift & w_data_bit);
`else
   assign w_ready = (r_state == IDLE) || w_last;
   assign done    = w_last;
   assign sout    = w_shift & w_data_bit;
`endif

   assign in_ready   = w_ready;
   assign sout_valid = (r_state != IDLE);
   assign dbg_state  = r_state;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = SHIFT;
         end
         SHIFT: begin
            if (w_last) begin
`ifdef PISO_PARITY_EN
               w_next = PARITY;
`else
               w_next = w_accept ? SHIFT : IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            w_next = w_accept ? SHIFT : IDLE;
         end
`endif
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if (w_shift) begin
         r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

   // Neighbour wiring moves the next bit to send toward the output end.
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      if (LSB_FIRST) begin : g_lsb
         if (i == WIDTH - 1) begin : g_end
            assign w_nbr[i] = 1'b0;
         end else begin : g_mid
            assign w_nbr[i] = r_sreg[i+1];
         end
      end else begin : g_msb
         if (i == 0) begin : g_end
            assign w_nbr[i] = 1'b0;
         end else begin : g_mid
            assign w_nbr[i] = r_sreg[i-1];
         end
      end

      piso_cell u_cell (
         .clk        (clk),
         .rst        (rst),
         .i_load     (w_accept),
         .i_shift    (w_shift),
         .i_load_val (in[i]),
         .i_nbr      (w_nbr[i]),
         .o_q        (r_sreg[i])
      );
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: one LSB-first and one MSB-first instance,
// expected {done, bit} pairs queued at stimulus time and compared as bits appear.
`timescale 1ns/1ps
module tb_piso_serializer;
   import piso_pkg::*;

   localparam int W = 4;
`ifdef PISO_PARITY_EN
   localparam bit PAR = 1'b1;
   localparam int FL  = W + 1;
`else
   localparam bit PAR = 1'b0;
   localparam int FL  = W;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [W-1:0]       in_a, in_b;
   logic               in_valid_a, in_valid_b;
   logic               in_ready_a, in_ready_b;
   logic               sout_a, sout_b;
   logic               sout_valid_a, sout_valid_b;
   logic               done_a, done_b;
   logic [STATE_W-1:0] dbg_state_a, dbg_state_b;

   logic [1:0] exp_a_q[$];
   logic [1:0] exp_b_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .in(in_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .sout(sout_a), .sout_valid(sout_valid_a), .done(done_a), .dbg_state(dbg_state_a)
   );

   piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .sout(sout_b), .sout_valid(sout_valid_b), .done(done_b), .dbg_state(dbg_state_b)
   );

   always #5 clk = ~clk;

   // Expected frame: data bits in the instance's order, then optional even parity; done on the last.
   task automatic push_frame(input bit sel_b, input logic [W-1:0] w);
      logic [1:0] item;
      for (int i = 0; i < W; i++) begin
         item = {((i == W - 1) && !PAR), (sel_b ? w[W-1-i] : w[i])};
         if (sel_b) exp_b_q.push_back(item); else exp_a_q.push_back(item);
      end
      if (PAR) begin
         item = {1'b1, ^w};
         if (sel_b) exp_b_q.push_back(item); else exp_a_q.push_back(item);
      end
   endtask

   always @(negedge clk) begin
      logic [1:0] item;
      n_checks++;
      if (sout_valid_a) begin
         if (exp_a_q.size() == 0) begin
            n_fail++;
            $display("FAIL mon_a_extra: bit sout=%0b done=%0b emitted, none expected", sout_a, done_a);
         end else begin
            item = exp_a_q.pop_front();
            if ({done_a, sout_a} !== item) begin
               n_fail++;
               $display("FAIL mon_a_bit: {done,sout}=%b expected %b at %0t", {done_a, sout_a}, item, $time);
            end
         end
      end else if (sout_a !== 1'b0 || done_a !== 1'b0) begin
         n_fail++;
         $display("FAIL mon_a_idle: sout=%0b done=%0b expected 0/0 while invalid", sout_a, done_a);
      end
   end

   always @(negedge clk) begin
      logic [1:0] item;
      n_checks++;
      if (sout_valid_b) begin
         if (exp_b_q.size() == 0) begin
            n_fail++;
            $display("FAIL mon_b_extra: bit sout=%0b done=%0b emitted, none expected", sout_b, done_b);
         end else begin
            item = exp_b_q.pop_front();
            if ({done_b, sout_b} !== item) begin
               n_fail++;
               $display("FAIL mon_b_bit: {done,sout}=%b expected %b at %0t", {done_b, sout_b}, item, $time);
            end
         end
      end else if (sout_b !== 1'b0 || done_b !== 1'b0) begin
         n_fail++;
         $display("FAIL mon_b_idle: sout=%0b done=%0b expected 0/0 while invalid", sout_b, done_b);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input bit sel_b, input logic [W-1:0] w);
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if ((sel_b ? in_ready_b : in_ready_a) === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL send_ready_timeout: in_ready=0 after 50 cycles, expected 1");
      end
      if (sel_b) begin in_b = w; in_valid_b = 1'b1; end
      else       begin in_a = w; in_valid_a = 1'b1; end
      push_frame(sel_b, w);
      tick();
      if (sel_b) begin in_valid_b = 1'b0; in_b = W'($urandom); end
      else       begin in_valid_a = 1'b0; in_a = W'($urandom); end
      n_checks++;
      if ((sel_b ? sout_valid_b : sout_valid_a) !== 1'b1) begin
         n_fail++;
         $display("FAIL first_bit_latency: sout_valid=0 one cycle after acceptance, expected 1");
      end
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 100; k++) begin
         if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
         tick();
      end
      tick();
      n_checks++;
      if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d/%0d bits outstanding, expected 0/0", name, exp_a_q.size(), exp_b_q.size());
         exp_a_q.delete();
         exp_b_q.delete();
      end
      n_checks++;
      if (sout_valid_a !== 1'b0 || in_ready_a !== 1'b1 || dbg_state_a !== IDLE) begin
         n_fail++;
         $display("FAIL %s_idle: sout_valid=%0b in_ready=%0b state=%0d, expected 0/1/IDLE",
                  name, sout_valid_a, in_ready_a, dbg_state_a);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid_a = 1'b0; in_valid_b = 1'b0;
      in_a = '0; in_b = '0;
      tick();
      tick();
      n_checks++;
      if (in_ready_a !== 1'b1 || sout_a !== 1'b0 || sout_valid_a !== 1'b0 || done_a !== 1'b0 ||
          dbg_state_a !== IDLE) begin
         n_fail++;
         $display("FAIL reset_a: rdy=%0b sout=%0b vld=%0b done=%0b st=%0d, expected 1/0/0/0/IDLE",
                  in_ready_a, sout_a, sout_valid_a, done_a, dbg_state_a);
      end
      n_checks++;
      if (in_ready_b !== 1'b1 || sout_b !== 1'b0 || sout_valid_b !== 1'b0 || done_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b: rdy=%0b sout=%0b vld=%0b done=%0b, expected 1/0/0/0",
                  in_ready_b, sout_b, sout_valid_b, done_b);
      end
      // Reset must win over a same-cycle acceptance.
      in_a = 4'b1111;
      in_valid_a = 1'b1;
      tick();
      in_valid_a = 1'b0;
      n_checks++;
      if (sout_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_priority: sout_valid=%0b in_ready=%0b, expected 0/1", sout_valid_a, in_ready_a);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      send_word(1'b0, 4'b1010);
      drain("single");
   endtask

   task automatic test_back_to_back();
      int dones = 0;
      in_a = 4'b1010;
      in_valid_a = 1'b1;
      push_frame(1'b0, 4'b1010);
      push_frame(1'b0, 4'b0101);
      tick();
      in_a = 4'b0101;
      for (int k = 1; k <= 2 * FL; k++) begin
         n_checks++;
         if (sout_valid_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_gap: sout_valid=0 on frame cycle %0d, expected 1", k);
         end
         if (done_a === 1'b1) dones++;
         if (k == FL + 1) in_valid_a = 1'b0;
         tick();
      end
      n_checks++;
      if (dones != 2) begin
         n_fail++;
         $display("FAIL b2b_done_count: %0d done pulses, expected 2", dones);
      end
      drain("b2b");
   endtask

   task automatic test_reset_midframe();
      send_word(1'b0, 4'b1100);
      repeat (FL - 2) void'(exp_a_q.pop_back());
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (sout_valid_a !== 1'b0 || sout_a !== 1'b0 || in_ready_a !== 1'b1 || done_a !== 1'b0) begin
         n_fail++;
         $display("FAIL abort: vld=%0b sout=%0b rdy=%0b done=%0b, expected 0/0/1/0",
                  sout_valid_a, sout_a, in_ready_a, done_a);
      end
      rst = 1'b0;
      repeat (FL + 2) tick();
      drain("abort");
   endtask

   task automatic test_input_change();
      in_a = 4'b0000;
      in_valid_a = 1'b1;
      push_frame(1'b0, 4'b0000);
      push_frame(1'b0, 4'b1111);
      tick();
      in_a = 4'b1111;
      for (int k = 1; k <= FL; k++) begin
         n_checks++;
         if (in_ready_a !== (k == FL)) begin
            n_fail++;
            $display("FAIL change_ready: in_ready=%0b on frame cycle %0d, expected %0b", in_ready_a, k, (k == FL));
         end
         tick();
      end
      in_valid_a = 1'b0;
      drain("change");
   endtask

   task automatic test_msb_first();
      send_word(1'b1, 4'b0001);
      drain("msb");
      send_word(1'b1, 4'b1101);
      drain("msb2");
   endtask

`ifdef PISO_PARITY_EN
   task automatic test_parity();
      send_word(1'b0, 4'b1011);
      drain("parity");
      send_word(1'b0, 4'b0110);
      drain("parity_even");
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] w;
      for (int n = 0; n < 10; n++) begin
         w = W'($urandom);
         send_word(1'b0, w);
         repeat ($urandom_range(0, FL + 2)) tick();
      end
      drain("random");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_midframe();
      test_input_change();
      test_msb_first();
`ifdef PISO_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
